// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, 12-bit h/v counters,
// active-area coordinates, and a registered sync/blank/colour output stage.
// Optional colour-bar source is compiled in when VGA_TIMING_PATTERN_EN is defined.
module vga_timing_gen #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic       clk,
    input  logic       reset,
`ifdef VGA_TIMING_PATTERN_EN
    input  logic       pattern_sel,
`endif
    input  logic [9:0] pix_r,
    input  logic [9:0] pix_g,
    input  logic [9:0] pix_b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       de,
    output logic       pix_ce,
    output logic       line_start,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank,
    output logic [9:0] vga_r,
    output logic [9:0] vga_g,
    output logic [9:0] vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0]  DIV_LAST  = 4'(PIX_DIV - 1);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
    localparam logic [11:0] H_SYN_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYN_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_SYN_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYN_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        HS_ACT    = (HS_POL != 0);
    localparam logic        VS_ACT    = (VS_POL != 0);

    // Counters are 12 bits wide and the divider 4 bits; reject anything larger.
    if (H_TOTAL > 4095) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL=%0d exceeds 4095", H_TOTAL);
    end
    if (V_TOTAL > 4095) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL=%0d exceeds 4095", V_TOTAL);
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_div_chk
        $error("vga_timing_gen: PIX_DIV=%0d outside 1..16", PIX_DIV);
    end
    if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_act_chk
        $error("vga_timing_gen: active area exceeds 10-bit x/y");
    end

    logic [3:0]  div_q, div_d;
    logic        pix_ce_q, pix_ce_d;
    logic        run_q, run_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] vcnt_q, vcnt_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_q, blank_d;
    logic [9:0]  r_q, r_d;
    logic [9:0]  g_q, g_d;
    logic [9:0]  b_q, b_d;

    logic        h_act, v_act, de_w;
    logic        hs_win, vs_win;
    logic        ls_w;
    logic [9:0]  x_w, y_w;
    logic [9:0]  src_r, src_g, src_b;

    // Pixel strobe: registered so that it is low in reset and its first
    // pulse arrives PIX_DIV clocks after release.
    always_comb begin
        pix_ce_d = (div_q == DIV_LAST);
        div_d    = pix_ce_d ? 4'd0 : div_q + 4'd1;
    end

    // Raster counters advance at the end of each pixel strobe clock.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        run_d  = run_q | pix_ce_q;
        if (pix_ce_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 12'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 12'd0;
                end else begin
                    vcnt_d = vcnt_q + 12'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
        end
    end

    // Region decode of the pixel currently presented; run gates de until
    // the first strobe so reset leaves the active-area flag low.
    always_comb begin
        h_act  = (hcnt_q < H_ACT_END);
        v_act  = (vcnt_q < V_ACT_END);
        de_w   = (run_q | pix_ce_q) & h_act & v_act;
        hs_win = (hcnt_q >= H_SYN_BEG) && (hcnt_q < H_SYN_END);
        vs_win = (vcnt_q >= V_SYN_BEG) && (vcnt_q < V_SYN_END);
        ls_w   = pix_ce_q && (hcnt_q == 12'd0);
        x_w    = de_w ? hcnt_q[9:0] : 10'd0;
        y_w    = de_w ? vcnt_q[9:0] : 10'd0;
    end

`ifdef VGA_TIMING_PATTERN_EN
    logic [12:0] bar_num;
    logic [2:0]  bar;

    // Eight equal-width vertical colour bars across the active width.
    always_comb begin
        bar_num = {x_w, 3'b000};
        bar     = 3'(bar_num / 13'(H_ACTIVE));
    end
`endif

    // Colour source select: external pixel inputs or the bar pattern.
    always_comb begin
        src_r = pix_r;
        src_g = pix_g;
        src_b = pix_b;
`ifdef VGA_TIMING_PATTERN_EN
        if (pattern_sel) begin
            src_r = {10{bar[2]}};
            src_g = {10{bar[1]}};
            src_b = {10{bar[0]}};
        end
`endif
    end

    // Output stage: capture the presented pixel at the end of its strobe,
    // giving a one-pixel lag behind x/y/de; colours forced to 0 in blanking.
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        blank_d = blank_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        if (pix_ce_q) begin
            hs_d    = hs_win ? HS_ACT : ~HS_ACT;
            vs_d    = vs_win ? VS_ACT : ~VS_ACT;
            blank_d = de_w;
            r_d     = de_w ? src_r : 10'd0;
            g_d     = de_w ? src_g : 10'd0;
            b_d     = de_w ? src_b : 10'd0;
        end
    end

    // State registers with asynchronous reset to the idle raster position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q    <= 4'd0;
            pix_ce_q <= 1'b0;
            run_q    <= 1'b0;
            hcnt_q   <= 12'd0;
            vcnt_q   <= 12'd0;
            hs_q     <= ~HS_ACT;
            vs_q     <= ~VS_ACT;
            blank_q  <= 1'b0;
            r_q      <= 10'd0;
            g_q      <= 10'd0;
            b_q      <= 10'd0;
        end else begin
            div_q    <= div_d;
            pix_ce_q <= pix_ce_d;
            run_q    <= run_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
        end
    end

    assign pix_ce      = pix_ce_q;
    assign de          = de_w;
    assign x           = x_w;
    assign y           = y_w;
    assign line_start  = ls_w;
    assign frame_start = ls_w && (vcnt_q == 12'd0);
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank   = blank_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 16x8 total raster.
// Boundary table, colour scoreboard, mid-frame reset and PIX_DIV=1 instance.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    localparam int PD = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, rst1;
    logic [9:0] pix_r, pix_g, pix_b;
    logic [9:0] x, y, vga_r, vga_g, vga_b;
    logic       de, pix_ce, line_start, frame_start;
    logic       vga_hs, vga_vs, vga_blank;
    logic [9:0] x1, y1, vga_r1, vga_g1, vga_b1;
    logic       de1, pix_ce1, line_start1, frame_start1;
    logic       vga_hs1, vga_vs1, vga_blank1;
    logic       pat_on;
`ifdef VGA_TIMING_PATTERN_EN
    logic       pattern_sel;
    assign pattern_sel = pat_on;
`endif

    vga_timing_gen #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0)
    ) dut (
        .clk(clk), .reset(reset),
`ifdef VGA_TIMING_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .x(x), .y(y), .de(de), .pix_ce(pix_ce),
        .line_start(line_start), .frame_start(frame_start),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    vga_timing_gen #(
        .PIX_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1), .VS_POL(0)
    ) dut1 (
        .clk(clk), .reset(rst1),
`ifdef VGA_TIMING_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .x(x1), .y(y1), .de(de1), .pix_ce(pix_ce1),
        .line_start(line_start1), .frame_start(frame_start1),
        .vga_hs(vga_hs1), .vga_vs(vga_vs1), .vga_blank(vga_blank1),
        .vga_r(vga_r1), .vga_g(vga_g1), .vga_b(vga_b1)
    );

    typedef struct {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } vexp_t;

    typedef struct {
        int   h;
        int   v;
        logic de;
        logic hs;
        logic vs;
        logic blank;
        logic ls;
        logic fs;
    } vec_t;

    vec_t  tbl[16];
    vexp_t sb[$];

    int checks = 0;
    int failures = 0;
    int k = 0;
    int k1 = 0;
    int clk_n = 0;
    int last_fs = -1;
    int de_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic int hpos(int p);
        return p % HT;
    endfunction

    function automatic int vpos(int p);
        return (p / HT) % VT;
    endfunction

    function automatic bit mde(int p);
        return (hpos(p) < HA) && (vpos(p) < VA);
    endfunction

    function automatic vexp_t exp_of(int p, logic pat);
        vexp_t e;
        int h, v, bar;
        h = hpos(p);
        v = vpos(p);
        e.hs    = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs    = !((v >= VA + VF) && (v < VA + VF + VS));
        e.blank = mde(p);
        e.r = 10'd0;
        e.g = 10'd0;
        e.b = 10'd0;
        if (mde(p)) begin
            if (pat) begin
                bar = h * 8 / HA;
                e.r = ((bar & 4) != 0) ? 10'd1023 : 10'd0;
                e.g = ((bar & 2) != 0) ? 10'd1023 : 10'd0;
                e.b = ((bar & 1) != 0) ? 10'd1023 : 10'd0;
            end else begin
                e.r = 10'(h * 100);
                e.g = 10'(v * 100 + h);
                e.b = 10'(1023 - h - v * 8);
            end
        end
        return e;
    endfunction

    task automatic drive(int p);
        if (mde(p)) begin
            pix_r = 10'(hpos(p) * 100);
            pix_g = 10'(vpos(p) * 100 + hpos(p));
            pix_b = 10'(1023 - hpos(p) - vpos(p) * 8);
        end else begin
            pix_r = 10'd1023;
            pix_g = 10'd512;
            pix_b = 10'd1023;
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_pix_ce"}, pix_ce, 0);
        chk({tag, "_de"}, de, 0);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_ls"}, line_start, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_hs"}, vga_hs, 1);
        chk({tag, "_vs"}, vga_vs, 1);
        chk({tag, "_blank"}, vga_blank, 0);
        chk({tag, "_r"}, vga_r, 0);
        chk({tag, "_g"}, vga_g, 0);
        chk({tag, "_b"}, vga_b, 0);
    endtask

    // One clock: advance, compare at the falling edge, drive next inputs.
    task automatic step();
        int    cp, hh, vv, cp1, pv;
        bit    strobe;
        vexp_t e;
        @(posedge clk);
        k++;
        k1++;
        clk_n++;
        @(negedge clk);
        strobe = (k >= PD) && (k % PD == 0);
        cp = (k >= PD) ? (k - 1) / PD : 0;
        hh = hpos(cp);
        vv = vpos(cp);
        chk("pix_ce", pix_ce, strobe);
        if (k >= PD) begin
            chk("x", x, mde(cp) ? hh : 0);
            chk("y", y, mde(cp) ? vv : 0);
            chk("de", de, mde(cp));
            chk("line_start", line_start, strobe && hh == 0);
            chk("frame_start", frame_start, strobe && hh == 0 && vv == 0);
        end else begin
            chk("de_pre", de, 0);
            chk("fs_pre", frame_start, 0);
        end
        if (strobe) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
            end else begin
                e = '{1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 10'd0};
            end
            chk("sb_hs", vga_hs, e.hs);
            chk("sb_vs", vga_vs, e.vs);
            chk("sb_blank", vga_blank, e.blank);
            chk("sb_r", vga_r, e.r);
            chk("sb_g", vga_g, e.g);
            chk("sb_b", vga_b, e.b);
            sb.push_back(exp_of(cp, pat_on));
            foreach (tbl[i]) begin
                if (tbl[i].h == hh && tbl[i].v == vv) begin
                    chk($sformatf("tbl%0d_de", i), de, tbl[i].de);
                    chk($sformatf("tbl%0d_hs", i), vga_hs, tbl[i].hs);
                    chk($sformatf("tbl%0d_vs", i), vga_vs, tbl[i].vs);
                    chk($sformatf("tbl%0d_blank", i), vga_blank, tbl[i].blank);
                    chk($sformatf("tbl%0d_ls", i), line_start, tbl[i].ls);
                    chk($sformatf("tbl%0d_fs", i), frame_start, tbl[i].fs);
                end
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) begin
                    chk("frame_period", clk_n - last_fs, 256);
                    chk("de_per_frame", de_cnt, VA * HA);
                end
                last_fs = clk_n;
                de_cnt = 0;
            end
            if (de === 1'b1) de_cnt++;
        end
        chk("pix_ce1", pix_ce1, k1 >= 1);
        cp1 = k1 - 1;
        if (cp1 <= 0) begin
            chk("hs1_rst", vga_hs1, 0);
        end else begin
            pv = hpos(cp1 - 1);
            chk("hs1", vga_hs1, (pv >= HA + HF) && (pv < HA + HF + HS));
        end
        drive(cp);
    endtask

    task automatic run_until(int th, int tv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (k >= PD && k % PD == 0 &&
                hpos((k - 1) / PD) == th && vpos((k - 1) / PD) == tv) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        tbl[0]  = '{0, 0, 1, 1, 1, 0, 1, 1};
        tbl[1]  = '{7, 0, 1, 1, 1, 1, 0, 0};
        tbl[2]  = '{8, 0, 0, 1, 1, 1, 0, 0};
        tbl[3]  = '{9, 0, 0, 1, 1, 0, 0, 0};
        tbl[4]  = '{10, 0, 0, 1, 1, 0, 0, 0};
        tbl[5]  = '{11, 0, 0, 0, 1, 0, 0, 0};
        tbl[6]  = '{13, 0, 0, 0, 1, 0, 0, 0};
        tbl[7]  = '{14, 0, 0, 1, 1, 0, 0, 0};
        tbl[8]  = '{0, 1, 1, 1, 1, 0, 1, 0};
        tbl[9]  = '{1, 1, 1, 1, 1, 1, 0, 0};
        tbl[10] = '{0, 4, 0, 1, 1, 0, 1, 0};
        tbl[11] = '{0, 5, 0, 1, 1, 0, 1, 0};
        tbl[12] = '{1, 5, 0, 1, 0, 0, 0, 0};
        tbl[13] = '{0, 7, 0, 1, 0, 0, 1, 0};
        tbl[14] = '{1, 7, 0, 1, 1, 0, 0, 0};
        tbl[15] = '{3, 3, 1, 1, 1, 1, 0, 0};

        pat_on = 1'b0;
        reset = 1'b1;
        rst1 = 1'b1;
        drive(0);
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        chk("rst_hs1", vga_hs1, 0);
        chk("rst_pix_ce1", pix_ce1, 0);
        reset = 1'b0;
        rst1 = 1'b0;
        k = 0;
        k1 = 0;

        for (int i = 0; i < 2 * 256 + 20; i++) step();

        run_until(5, 2, ok);
        chk("reach_5_2", ok, 1);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk);
        k1++;
        clk_n++;
        @(negedge clk);
        chk_reset_vals("midrst_hold");
        reset = 1'b0;
        k = 0;
        sb.delete();
        last_fs = -1;
        de_cnt = 0;
        drive(0);
        step();
        chk("rel_pix_ce_k1", pix_ce, 0);
        step();
        chk("rel_pix_ce_k2", pix_ce, 1);
        chk("rel_fs", frame_start, 1);
        chk("rel_x", x, 0);
        chk("rel_y", y, 0);
        for (int i = 0; i < 270; i++) step();

`ifdef VGA_TIMING_PATTERN_EN
        pat_on = 1'b1;
        run_until(1, 1, ok);
        chk("pat_reach_1_1", ok, 1);
        chk("pat_x0_r", vga_r, 0);
        chk("pat_x0_g", vga_g, 0);
        chk("pat_x0_b", vga_b, 0);
        run_until(5, 1, ok);
        chk("pat_reach_5_1", ok, 1);
        chk("pat_x4_r", vga_r, 1023);
        chk("pat_x4_g", vga_g, 0);
        run_until(8, 1, ok);
        chk("pat_reach_8_1", ok, 1);
        chk("pat_x7_r", vga_r, 1023);
        chk("pat_x7_g", vga_g, 1023);
        chk("pat_x7_b", vga_b, 1023);
        for (int i = 0; i < 40; i++) step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
